rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (addr1/data1/en_1) among NUM_REQ writeback requesters, e.g. ALU writeback, load writeback and a debug/config loader.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered outputs drive the register file write port directly.
- An 8-entry pending-write scoreboard gives decode the busy bits it needs to stall on read-after-write hazards.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..4).
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width (2**ADDR_W registers).

Ports:
- In_clock  input  1  system clock, all state on rising edge.
- In_reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_W  packed target addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant; request accepted when valid&&ready.
- claim_valid  input  1  issue stage reserves a destination register.
- claim_addr  input  ADDR_W  register being reserved.
- Out_RF_Write_en_1  output  1  to register file write enable.
- Out_RF_Write_addr1  output  ADDR_W  to register file write address.
- Out_RF_Write_data1  output  DATA_W  to register file write data.
- busy_bits  output  2**ADDR_W  scoreboard; bit r=1 means a write to r is pending.
- claim_conflict  output  1  one-cycle pulse: claim hit an already-busy register.
- grant_id  output  2  index of requester whose write is currently on the output port.

Behaviour:
- Reset (async, In_reset=1):
  - Out_RF_Write_en_1=0, Out_RF_Write_addr1=0, Out_RF_Write_data1=0.
  - busy_bits=0, claim_conflict=0, grant_id=0, RR pointer=0.
  - req_ready=0 while In_reset=1.
  - Any in-flight accepted write is dropped.
- Arbitration (combinational from req_valid and pointer):
  - Search starts at the pointer index and wraps modulo NUM_REQ.
  - The first valid requester gets req_ready=1; all other ready bits are 0.
  - No valid requests: req_ready=0.
  - At most one grant per cycle; the port never idles while any request is valid.
- Pointer:
  - After an accept by requester i, pointer = (i+1) mod NUM_REQ at the next edge.
  - Unchanged when nothing is accepted.
  - Guarantees no requester waits more than NUM_REQ-1 grants.
- Latency: accept at edge t gives Out_RF_Write_en_1=1 with that addr/data and grant_id=i for exactly the cycle following edge t. The register file commits at edge t+1.
- Back-to-back accepts give a continuous en=1 stream, one write per cycle.
- Requesters must hold addr/data stable while valid&&!ready; a request may not be withdrawn before acceptance. The bench asserts both.
- Scoreboard:
  - claim_valid sets busy_bits[claim_addr] at the next edge.
  - A write leaving the output stage clears busy_bits[addr] at the edge that ends its en=1 cycle.
  - Claim and clear of the same address at the same edge: set wins (the newer instruction owns the register).
  - Claim to an already-busy bit: bit stays 1, claim_conflict=1 for one cycle.
  - A write to a non-busy register is legal: no flag, bit stays 0.
- Reset mid-operation: all state clears asynchronously, and the write pending on the port is lost. Pairs with the register file's synchronous clear; writes resume on the first edge after deassertion.

Test Plan:
- Reset then idle: after deassertion all outputs 0, req_ready=0, busy_bits=8'h00.
- Single request: req 1 valid, addr=3, data=16'hBEEF held 1 cycle -> req_ready=3'b010 that cycle; next cycle en=1, addr1=3, data1=16'hBEEF, grant_id=1; then en=0.
- Round-robin: all three valid continuously from reset -> grant order 0,1,2,0,1,2 over 6 cycles; en=1 each cycle after the first.
- Scoreboard: claim addr 5 -> busy_bits=8'h20. Req 0 writes addr 5 -> busy clears at the edge ending its en cycle. Claim addr 5 in that same cycle -> busy stays 8'h20.
- Conflict: claim addr 2 twice on consecutive cycles -> claim_conflict pulses once on the second; busy_bits[2]=1.
- Async reset mid-stream: raise In_reset between edges while en=1 -> en, busy_bits and pointer drop to 0 immediately. After release, req 2 alone valid -> granted first cycle.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Requester bus for the register-file write arbiter: one valid/addr/data lane per requester plus a one-hot ready.
// Requesters hold addr/data steady while valid is up and ready is low.
interface rf_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin share of the register-file write port plus a pending-write scoreboard; accept at edge t drives the port
// for the cycle after t. Unselected requesters see ready low and must hold their request; ready is low during reset.
module rf_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3
) (
    input  logic                   In_clock,
    input  logic                   In_reset,
    rf_write_arbiter_if.slave      req,
    input  logic                   claim_valid,
    input  logic [ADDR_W-1:0]      claim_addr,
    output logic                   Out_RF_Write_en_1,
    output logic [ADDR_W-1:0]      Out_RF_Write_addr1,
    output logic [DATA_W-1:0]      Out_RF_Write_data1,
    output logic [2**ADDR_W-1:0]   busy_bits,
    output logic                   claim_conflict,
    output logic [1:0]             grant_id
);
    localparam int         NREG = 2**ADDR_W;
    localparam logic [1:0] LAST = 2'(NUM_REQ - 1);

    logic [1:0]         ptr;
    logic [1:0]         sel;
    logic [1:0]         ptr_nxt;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic [NREG-1:0]    busy_nxt;

    // Priority order is ptr, ptr+1, ... wrapping; the first valid lane in that order wins.
    always_comb begin
        grant    = '0;
        sel      = '0;
        sel_addr = '0;
        sel_data = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req.req_valid[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    sel      = 2'(i);
                    sel_addr = req.req_addr[i*ADDR_W +: ADDR_W];
                    sel_data = req.req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign req.req_ready = In_reset ? '0 : grant;
    assign ptr_nxt       = (sel == LAST) ? 2'd0 : sel + 2'd1;

    // Clear for the write leaving the port first, so a same-edge claim of that register wins.
    always_comb begin
        busy_nxt = busy_bits;
        if (Out_RF_Write_en_1)
            busy_nxt[Out_RF_Write_addr1] = 1'b0;
        if (claim_valid)
            busy_nxt[claim_addr] = 1'b1;
    end

    always_ff @(posedge In_clock or posedge In_reset) begin
        if (In_reset) begin
            ptr                <= '0;
            Out_RF_Write_en_1  <= 1'b0;
            Out_RF_Write_addr1 <= '0;
            Out_RF_Write_data1 <= '0;
            grant_id           <= '0;
            busy_bits          <= '0;
            claim_conflict     <= 1'b0;
        end else begin
            Out_RF_Write_en_1 <= found;
            if (found) begin
                Out_RF_Write_addr1 <= sel_addr;
                Out_RF_Write_data1 <= sel_data;
                grant_id           <= sel;
                ptr                <= ptr_nxt;
            end
            busy_bits      <= busy_nxt;
            claim_conflict <= claim_valid && busy_bits[claim_addr];
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a vector table applied one cycle per entry, then hand-written
// sequences for reset, asynchronous reset mid-stream and pointer reset.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        claim_valid;
    logic [2:0]  claim_addr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  busy_bits;
    logic        claim_conflict;
    logic [1:0]  grant_id;

    int nvec = 0;
    int nmis = 0;

    rf_write_arbiter_if #(.NUM_REQ(3), .DATA_W(16), .ADDR_W(3)) bus ();

    rf_write_arbiter #(.NUM_REQ(3), .DATA_W(16), .ADDR_W(3)) dut (
        .In_clock           (clk),
        .In_reset           (rst),
        .req                (bus.slave),
        .claim_valid        (claim_valid),
        .claim_addr         (claim_addr),
        .Out_RF_Write_en_1  (wr_en),
        .Out_RF_Write_addr1 (wr_addr),
        .Out_RF_Write_data1 (wr_data),
        .busy_bits          (busy_bits),
        .claim_conflict     (claim_conflict),
        .grant_id           (grant_id)
    );

    always #5 clk = ~clk;

    // Requester protocol: a stalled request stays valid with unchanged addr/data.
    for (genvar g = 0; g < 3; g++) begin : g_proto
        assert property (@(posedge clk) disable iff (rst)
            (bus.req_valid[g] && !bus.req_ready[g]) |=>
                (bus.req_valid[g] && $stable(bus.req_addr[g*3 +: 3]) && $stable(bus.req_data[g*16 +: 16])))
            else $error("FAIL proto req%0d withdrawn or changed while stalled", g);
    end

    typedef struct {
        logic [2:0]  v;
        logic [8:0]  a;
        logic [47:0] d;
        logic        cv;
        logic [2:0]  ca;
        logic [2:0]  rdy;
        logic        en;
        logic [2:0]  oa;
        logic [15:0] od;
        logic [1:0]  gid;
        logic [7:0]  busy;
        logic        conf;
    } vec_t;

    function automatic vec_t mk(logic [2:0] v, logic [8:0] a, logic [47:0] d, logic cv, logic [2:0] ca,
                                logic [2:0] rdy, logic en, logic [2:0] oa, logic [15:0] od, logic [1:0] gid,
                                logic [7:0] busy, logic conf);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.cv = cv; r.ca = ca;
        r.rdy = rdy; r.en = en; r.oa = oa; r.od = od; r.gid = gid; r.busy = busy; r.conf = conf;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_port(input string nm, input logic en, input logic [2:0] a, input logic [15:0] d,
                            input logic [1:0] gid);
        chk({nm, " en"}, 64'(wr_en), 64'(en));
        if (en) begin
            chk({nm, " addr"}, 64'(wr_addr), 64'(a));
            chk({nm, " data"}, 64'(wr_data), 64'(d));
            chk({nm, " gid"},  64'(grant_id), 64'(gid));
        end
    endtask

    localparam logic [8:0]  A_RR = {3'd4, 3'd2, 3'd1};
    localparam logic [47:0] D_RR = {16'hC002, 16'hB001, 16'hA000};
    localparam logic [8:0]  A_PR = {3'd6, 3'd7, 3'd0};
    localparam logic [47:0] D_PR = {16'h6666, 16'h7777, 16'h0000};

    vec_t tv[26];

    initial begin
        tv[0]  = mk(3'b000, 9'd0, 48'd0, 0, 3'd0, 3'b000, 0, 3'd0, 16'h0,    2'd0, 8'h00, 0);
        // all three requesting from reset: 0,1,2,0,1,2 then drain 0 and 1
        tv[1]  = mk(3'b111, A_RR, D_RR,  0, 3'd0, 3'b001, 1, 3'd1, 16'hA000, 2'd0, 8'h00, 0);
        tv[2]  = mk(3'b111, A_RR, D_RR,  0, 3'd0, 3'b010, 1, 3'd2, 16'hB001, 2'd1, 8'h00, 0);
        tv[3]  = mk(3'b111, A_RR, D_RR,  0, 3'd0, 3'b100, 1, 3'd4, 16'hC002, 2'd2, 8'h00, 0);
        tv[4]  = mk(3'b111, A_RR, D_RR,  0, 3'd0, 3'b001, 1, 3'd1, 16'hA000, 2'd0, 8'h00, 0);
        tv[5]  = mk(3'b111, A_RR, D_RR,  0, 3'd0, 3'b010, 1, 3'd2, 16'hB001, 2'd1, 8'h00, 0);
        tv[6]  = mk(3'b111, A_RR, D_RR,  0, 3'd0, 3'b100, 1, 3'd4, 16'hC002, 2'd2, 8'h00, 0);
        tv[7]  = mk(3'b011, A_RR, D_RR,  0, 3'd0, 3'b001, 1, 3'd1, 16'hA000, 2'd0, 8'h00, 0);
        tv[8]  = mk(3'b010, A_RR, D_RR,  0, 3'd0, 3'b010, 1, 3'd2, 16'hB001, 2'd1, 8'h00, 0);
        tv[9]  = mk(3'b000, 9'd0, 48'd0, 0, 3'd0, 3'b000, 0, 3'd0, 16'h0,    2'd0, 8'h00, 0);
        // lone request, pointer at 2
        tv[10] = mk(3'b010, {3'd0, 3'd3, 3'd0}, {16'h0, 16'hBEEF, 16'h0}, 0, 3'd0, 3'b010, 1, 3'd3, 16'hBEEF, 2'd1, 8'h00, 0);
        tv[11] = mk(3'b000, 9'd0, 48'd0, 0, 3'd0, 3'b000, 0, 3'd0, 16'h0,    2'd0, 8'h00, 0);
        // scoreboard on register 5, including claim in the clearing cycle
        tv[12] = mk(3'b000, 9'd0, 48'd0, 1, 3'd5, 3'b000, 0, 3'd0, 16'h0,    2'd0, 8'h20, 0);
        tv[13] = mk(3'b001, {3'd0, 3'd0, 3'd5}, {16'h0, 16'h0, 16'h5555}, 0, 3'd0, 3'b001, 1, 3'd5, 16'h5555, 2'd0, 8'h20, 0);
        tv[14] = mk(3'b000, 9'd0, 48'd0, 1, 3'd5, 3'b000, 0, 3'd0, 16'h0,    2'd0, 8'h20, 1);
        tv[15] = mk(3'b010, {3'd0, 3'd5, 3'd0}, {16'h0, 16'h7777, 16'h0}, 0, 3'd0, 3'b010, 1, 3'd5, 16'h7777, 2'd1, 8'h20, 0);
        tv[16] = mk(3'b000, 9'd0, 48'd0, 0, 3'd0, 3'b000, 0, 3'd0, 16'h0,    2'd0, 8'h00, 0);
        // double claim of register 2, then its write clears it
        tv[17] = mk(3'b000, 9'd0, 48'd0, 1, 3'd2, 3'b000, 0, 3'd0, 16'h0,    2'd0, 8'h04, 0);
        tv[18] = mk(3'b000, 9'd0, 48'd0, 1, 3'd2, 3'b000, 0, 3'd0, 16'h0,    2'd0, 8'h04, 1);
        tv[19] = mk(3'b000, 9'd0, 48'd0, 0, 3'd0, 3'b000, 0, 3'd0, 16'h0,    2'd0, 8'h04, 0);
        tv[20] = mk(3'b100, {3'd2, 3'd0, 3'd0}, {16'h2222, 16'h0, 16'h0}, 0, 3'd0, 3'b100, 1, 3'd2, 16'h2222, 2'd2, 8'h04, 0);
        tv[21] = mk(3'b000, 9'd0, 48'd0, 0, 3'd0, 3'b000, 0, 3'd0, 16'h0,    2'd0, 8'h00, 0);
        // contention between 1 and 2 across the wrap
        tv[22] = mk(3'b110, A_PR, D_PR,  0, 3'd0, 3'b010, 1, 3'd7, 16'h7777, 2'd1, 8'h00, 0);
        tv[23] = mk(3'b110, A_PR, D_PR,  0, 3'd0, 3'b100, 1, 3'd6, 16'h6666, 2'd2, 8'h00, 0);
        tv[24] = mk(3'b010, A_PR, D_PR,  0, 3'd0, 3'b010, 1, 3'd7, 16'h7777, 2'd1, 8'h00, 0);
        tv[25] = mk(3'b001, {3'd0, 3'd0, 3'd3}, {16'h0, 16'h0, 16'h3333}, 1, 3'd3, 3'b001, 1, 3'd3, 16'h3333, 2'd0, 8'h08, 0);

        // reset with requests already raised
        rst = 1'b1; claim_valid = 1'b0; claim_addr = '0;
        bus.req_valid = 3'b111; bus.req_addr = A_RR; bus.req_data = D_RR;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rdy",  64'(bus.req_ready), 64'(3'b000));
        chk("reset en",   64'(wr_en), 64'(0));
        chk("reset addr", 64'(wr_addr), 64'(0));
        chk("reset data", 64'(wr_data), 64'(0));
        chk("reset gid",  64'(grant_id), 64'(0));
        chk("reset busy", 64'(busy_bits), 64'(8'h00));
        chk("reset conf", 64'(claim_conflict), 64'(0));
        @(negedge clk);
        rst = 1'b0; bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            bus.req_valid = tv[i].v; bus.req_addr = tv[i].a; bus.req_data = tv[i].d;
            claim_valid = tv[i].cv; claim_addr = tv[i].ca;
            #1;
            chk($sformatf("v%0d rdy", i), 64'(bus.req_ready), 64'(tv[i].rdy));
            @(posedge clk);
            #1;
            chk_port($sformatf("v%0d", i), tv[i].en, tv[i].oa, tv[i].od, tv[i].gid);
            chk($sformatf("v%0d busy", i), 64'(busy_bits), 64'(tv[i].busy));
            chk($sformatf("v%0d conf", i), 64'(claim_conflict), 64'(tv[i].conf));
        end

        // accept req 0 (pointer -> 1) with a claim, then assert reset between edges
        @(negedge clk);
        bus.req_valid = 3'b001; bus.req_addr = {3'd0, 3'd0, 3'd1}; bus.req_data = {16'h0, 16'h0, 16'hD00D};
        claim_valid = 1'b1; claim_addr = 3'd6;
        @(posedge clk);
        #1;
        chk_port("pre-rst", 1'b1, 3'd1, 16'hD00D, 2'd0);
        chk("pre-rst busy", 64'(busy_bits), 64'(8'h40));
        #1 rst = 1'b1;
        #1;
        chk("mid-rst en",   64'(wr_en), 64'(0));
        chk("mid-rst busy", 64'(busy_bits), 64'(8'h00));
        chk("mid-rst rdy",  64'(bus.req_ready), 64'(3'b000));
        @(negedge clk);
        bus.req_valid = '0; claim_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("in-rst en", 64'(wr_en), 64'(0));
        // pointer must be back at 0: 0 beats 1
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 3'b011; bus.req_addr = {3'd0, 3'd5, 3'd4}; bus.req_data = {16'h0, 16'h1234, 16'h4321};
        #1;
        chk("post-rst rdy", 64'(bus.req_ready), 64'(3'b001));
        @(posedge clk);
        #1;
        chk_port("post-rst", 1'b1, 3'd4, 16'h4321, 2'd0);
        @(negedge clk);
        bus.req_valid = 3'b010;
        #1;
        chk("post-rst2 rdy", 64'(bus.req_ready), 64'(3'b010));
        @(posedge clk);
        #1;
        chk_port("post-rst2", 1'b1, 3'd5, 16'h1234, 2'd1);

        // second mid-stream reset, then req 2 alone is granted on the first cycle
        @(negedge clk);
        bus.req_valid = 3'b111; bus.req_addr = A_RR; bus.req_data = D_RR;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst2 en", 64'(wr_en), 64'(0));
        @(negedge clk);
        bus.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 3'b100; bus.req_addr = {3'd7, 3'd0, 3'd0}; bus.req_data = {16'hCAFE, 16'h0, 16'h0};
        #1;
        chk("rst2 rdy", 64'(bus.req_ready), 64'(3'b100));
        @(posedge clk);
        #1;
        chk_port("rst2 first", 1'b1, 3'd7, 16'hCAFE, 2'd2);
        @(negedge clk);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        chk("rst2 idle en", 64'(wr_en), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
